// File: rtl/lcd_pkg.sv
// Shared types and constants for the character LCD bus arbiter.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    SETUP,
    PULSE,
    WAIT,
    IDLE
  } state_t;

  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME       = 8'h02;
  localparam logic [7:0] CMD_ENTRY      = 8'h06;
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] CMD_FUNC_8B2L  = 8'h38;

  localparam int INIT_LEN = 6;

  // Entry 0 is sent first: 38, 38, 38, 0C, 01, 06.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
    CMD_ENTRY, CMD_CLEAR, CMD_DISP_ON,
    CMD_FUNC_8B2L, CMD_FUNC_8B2L, CMD_FUNC_8B2L
  };

  // Clear (0x01) and home (0x02/0x03) are the only slow commands; both have
  // the same all-zero upper six bits as CMD_HOME.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return (!rs) && (d[7:2] == CMD_HOME[7:2]);
  endfunction

endpackage

// File: rtl/lcd_bus_arbiter_timer.sv
// Loadable down-counter shared by every delay of the LCD bus sequencer.
// A state that loads N stays active for exactly N cycles: done is raised
// while the count is 1, so the owning FSM leaves on the following edge.
module lcd_timer #(
  parameter int W       = 20,
  parameter int RST_VAL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt;

  // Count down to zero; reset preloads the power-up delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= W'(RST_VAL);
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/lcd_bus_arbiter.sv
// HD44780-style LCD bus owner: power-up init, two-client round-robin
// arbitration with burst locking, E-strobe timing and command wait.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = 2,
  parameter int E_HIGH_CYC     = 25,
  parameter int SHORT_WAIT_CYC = 2000,
  parameter int LONG_WAIT_CYC  = 82000,
  parameter int POWERUP_CYC    = 750000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [1:0]  rs_in,
  input  logic [15:0] data_in,
  input  logic [1:0]  last,
  output logic [1:0]  ack,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        init_done,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e
);

  localparam int TW = $clog2(POWERUP_CYC + 1);

  localparam logic [TW-1:0] T_SETUP = TW'(SETUP_CYC);
  localparam logic [TW-1:0] T_EHIGH = TW'(E_HIGH_CYC);
  localparam logic [TW-1:0] T_SHORT = TW'(SHORT_WAIT_CYC);
  localparam logic [TW-1:0] T_LONG  = TW'(LONG_WAIT_CYC);

  state_t        state;
  logic [2:0]    init_idx;
  logic [2:0]    idx_nxt;
  logic          cur;      // index of the client holding the grant
  logic          ptr;      // round-robin preference when both request
  logic          last_q;   // last flag latched with the byte in flight

  logic          arb;
  logic          csel;
  logic          c_rs;
  logic          c_last;
  logic [7:0]    c_data;

  logic          tmr_load;
  logic          tmr_done;
  logic [TW-1:0] tmr_val;

  assign idx_nxt = init_idx + 3'd1;

  // Pick the client to latch from: arbitration result in IDLE, owner otherwise.
  always_comb begin
    arb    = (req == 2'b11) ? ptr : req[1];
    csel   = (state == IDLE) ? arb : cur;
    c_rs   = rs_in[csel];
    c_last = last[csel];
    c_data = csel ? data_in[15:8] : data_in[7:0];
  end

  // Reload the timer with the length of whichever state is entered next.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = T_SETUP;
    unique case (state)
      IDLE:  tmr_load = |req;
      SETUP: begin
        tmr_load = tmr_done;
        tmr_val  = T_EHIGH;
      end
      PULSE: begin
        tmr_load = tmr_done;
        tmr_val  = is_long_cmd(lcd_rs, lcd_data) ? T_LONG : T_SHORT;
      end
      default: tmr_load = tmr_done;
    endcase
  end

  lcd_timer #(
    .W       (TW),
    .RST_VAL (POWERUP_CYC)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_val),
    .done  (tmr_done)
  );

  // Bus sequencer: init ROM playback, then grant/latch/strobe/wait per byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PWRUP;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
      grant     <= 2'b00;
      ack       <= 2'b00;
      init_done <= 1'b0;
      ptr       <= 1'b0;
      cur       <= 1'b0;
      last_q    <= 1'b0;
      init_idx  <= 3'd0;
    end else begin
      ack <= 2'b00;
      unique case (state)
        PWRUP: begin
          if (tmr_done) begin
            state    <= SETUP;
            lcd_rs   <= 1'b0;
            lcd_data <= INIT_ROM[0];
            init_idx <= 3'd0;
          end
        end
        SETUP: begin
          if (tmr_done) begin
            state <= PULSE;
            lcd_e <= 1'b1;
          end
        end
        PULSE: begin
          if (tmr_done) begin
            state <= WAIT;
            lcd_e <= 1'b0;
          end
        end
        WAIT: begin
          if (tmr_done) begin
            if (!init_done) begin
              if (init_idx == 3'(INIT_LEN - 1)) begin
                init_done <= 1'b1;
                state     <= IDLE;
              end else begin
                init_idx <= idx_nxt;
                lcd_data <= INIT_ROM[idx_nxt];
                state    <= SETUP;
              end
            end else if (!last_q && req[cur]) begin
              // Burst continues straight into the next byte, no IDLE cycle.
              ack      <= cur ? 2'b10 : 2'b01;
              lcd_rs   <= c_rs;
              lcd_data <= c_data;
              last_q   <= c_last;
              state    <= SETUP;
            end else begin
              grant <= 2'b00;
              ptr   <= ~cur;
              state <= IDLE;
            end
          end
        end
        IDLE: begin
          if (|req) begin
            cur      <= arb;
            grant    <= arb ? 2'b10 : 2'b01;
            ack      <= arb ? 2'b10 : 2'b01;
            lcd_rs   <= c_rs;
            lcd_data <= c_data;
            last_q   <= c_last;
            state    <= SETUP;
          end
        end
        default: state <= PWRUP;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter with shortened timing parameters.
module tb_lcd_bus_arbiter;

  localparam int S  = 2;   // setup cycles
  localparam int E  = 3;   // E high cycles
  localparam int SH = 5;   // short wait
  localparam int L  = 9;   // long wait
  localparam int P  = 20;  // power-up delay

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  rs_in = 2'b00;
  logic [15:0] data_in = 16'h0000;
  logic [1:0]  last = 2'b00;
  logic [1:0]  ack, grant;
  logic        busy, init_done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0]  lcd_data;

  lcd_bus_arbiter #(
    .SETUP_CYC(S), .E_HIGH_CYC(E), .SHORT_WAIT_CYC(SH),
    .LONG_WAIT_CYC(L), .POWERUP_CYC(P)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rs_in(rs_in), .data_in(data_in),
    .last(last), .ack(ack), .grant(grant), .busy(busy), .init_done(init_done),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- client queues and driver ----------------
  typedef struct packed {
    logic       rs;
    logic [7:0] d;
    logic       lst;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  bit   rnd_en = 1'b0;

  task automatic push(input int c, input logic r, input logic [7:0] d, input logic l);
    ent_t e;
    e.rs = r; e.d = d; e.lst = l;
    if (c == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic gen_burst(input int c);
    int len;
    len = $urandom_range(1, 3);
    for (int i = 0; i < len; i++) begin
      push(c, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom),
           (i == len - 1) ? ($urandom_range(0, 7) != 0) : 1'b0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req = 2'b00;
      end else begin
        if (ack[0] && q0.size() > 0) q0.delete(0);
        if (ack[1] && q1.size() > 0) q1.delete(0);
        if (rnd_en && q0.size() == 0 && $urandom_range(0, 5) == 0) gen_burst(0);
        if (rnd_en && q1.size() == 0 && $urandom_range(0, 5) == 0) gen_burst(1);
        if (q0.size() > 0) begin
          req[0] = 1'b1; rs_in[0] = q0[0].rs; data_in[7:0] = q0[0].d; last[0] = q0[0].lst;
        end else begin
          req[0] = 1'b0; data_in[7:0] = 8'($urandom); rs_in[0] = 1'($urandom);
        end
        if (q1.size() > 0) begin
          req[1] = 1'b1; rs_in[1] = q1[0].rs; data_in[15:8] = q1[0].d; last[1] = q1[0].lst;
        end else begin
          req[1] = 1'b0; data_in[15:8] = 8'($urandom); rs_in[1] = 1'($urandom);
        end
      end
    end
  end

  // ---------------- behavioural model ----------------
  // A byte in flight is described by its age m_t (cycles since it was
  // latched) and its total duration; outputs follow from the age.
  logic [7:0] rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  int   m_pwr = 0, m_icnt = 0, m_owner = -1, m_ptr = 0, m_t = 0, m_dur = 0;
  bit   m_active = 0, m_inited = 0, m_rs = 0, m_last = 0;
  logic [7:0] m_data = 8'h00;

  task automatic m_start(input logic [7:0] d, input logic r, input logic l);
    m_data = d; m_rs = r; m_last = l; m_t = 0; m_active = 1;
    m_dur = S + E + ((r == 1'b0 && d < 8'd4) ? L : SH);
  endtask

  task automatic m_start_client(input int c);
    m_start(data_in[8*c +: 8], rs_in[c], last[c]);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pwr = 0; m_icnt = 0; m_owner = -1; m_ptr = 0; m_t = 0; m_dur = 0;
        m_active = 0; m_inited = 0; m_rs = 0; m_last = 0; m_data = 8'h00;
      end else if (m_pwr < P) begin
        m_pwr++;
        if (m_pwr == P) m_start(rom[0], 1'b0, 1'b0);
      end else if (m_active) begin
        m_t++;
        if (m_t == m_dur) begin
          m_active = 0;
          if (!m_inited) begin
            m_icnt++;
            if (m_icnt == 6) m_inited = 1;
            else m_start(rom[m_icnt], 1'b0, 1'b0);
          end else if (m_owner >= 0) begin
            if (!m_last && req[m_owner]) m_start_client(m_owner);
            else begin
              m_ptr = 1 - m_owner;
              m_owner = -1;
            end
          end
        end
      end else if (m_inited && req != 2'b00) begin
        m_owner = (req == 2'b11) ? m_ptr : (req[1] ? 1 : 0);
        m_start_client(m_owner);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("lcd_e", lcd_e, (m_active && m_t >= S && m_t < S + E) ? 1 : 0);
      chk("lcd_data", lcd_data, m_data);
      chk("lcd_rs", lcd_rs, m_rs);
      chk("lcd_rw", lcd_rw, 0);
      chk("grant", grant, (m_owner >= 0) ? (1 << m_owner) : 0);
      chk("ack", ack, (m_active && m_t == 0 && m_owner >= 0) ? (1 << m_owner) : 0);
      chk("busy", busy, (m_inited && !m_active) ? 0 : 1);
      chk("init_done", init_done, m_inited);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, errors so far %0d", n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- directed helpers ----------------
  task automatic count_grant(input logic [1:0] g, output int n);
    int b;
    b = 0; n = 0;
    while (grant !== g && b < 400) begin @(negedge clk); b++; end
    chk("grant_seen", grant, g);
    while (grant === g && n < 400) begin n++; @(negedge clk); end
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((busy || q0.size() > 0 || q1.size() > 0) && b < 2000) begin @(negedge clk); b++; end
    chk("idle_reached", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic first_rise(output int cyc);
    cyc = 0;
    while (!lcd_e && cyc < 200) begin @(negedge clk); cyc++; end
  endtask

  // ---------------- main sequence ----------------
  int rises[6];
  logic [7:0] rdat[6];
  int widths[6];
  int nr, cyc, n, na;
  logic pe;
  int rt[3];
  logic [7:0] rdv[3];
  logic [7:0] exp_init[6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  logic [7:0] exp_burst[3] = '{8'h36, 8'h37, 8'h30};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_lcd_e", lcd_e, 0);
    chk("rst_lcd_data", lcd_data, 8'h00);
    chk("rst_grant", grant, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 1);
    chk("rst_init_done", init_done, 0);

    // Init sequence: first rise after P+S=22 edges; bytes 10 cycles apart,
    // except 0x01 which takes 2+3+9=14; done after 20+4*10+14+10=84 edges.
    rst_n = 1'b1;
    nr = 0; cyc = 0; pe = 1'b0;
    while (!init_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (lcd_e && !pe) begin
        if (nr < 6) begin rises[nr] = cyc; rdat[nr] = lcd_data; widths[nr] = 0; end
        nr++;
      end
      if (lcd_e && nr >= 1 && nr <= 6) widths[nr-1]++;
      pe = lcd_e;
    end
    chk("init_done_seen", init_done, 1);
    chk("init_done_cycle", cyc, 84);
    chk("init_pulses", nr, 6);
    chk("init_first_rise", rises[0], 22);
    chk("init_spacing_short", rises[1] - rises[0], 10);
    chk("init_spacing_after_clear", rises[5] - rises[4], 14);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("init_byte%0d", i), rdat[i], exp_init[i]);
      chk($sformatf("init_ewidth%0d", i), widths[i], E);
    end
    repeat (2) @(negedge clk);

    // Both clients request at once: pointer starts at client 0.
    push(0, 1'b1, 8'h41, 1'b0);
    push(0, 1'b1, 8'h42, 1'b1);
    push(1, 1'b1, 8'h43, 1'b1);
    n = 0;
    while (grant === 2'b00 && n < 100) begin @(negedge clk); n++; end
    chk("both_first_grant", grant, 2'b01);
    n = 0;
    while (grant === 2'b01 && n < 100) begin @(negedge clk); n++; end
    chk("both_c0_cycles", n, 20);
    chk("both_gap_grant", grant, 2'b00);
    @(negedge clk);
    chk("both_second_grant", grant, 2'b10);
    wait_idle();

    // Client 0 burst "670", data register writes.
    push(0, 1'b1, 8'h36, 1'b0);
    push(0, 1'b1, 8'h37, 1'b0);
    push(0, 1'b1, 8'h30, 1'b1);
    n = 0;
    while (grant !== 2'b01 && n < 100) begin @(negedge clk); n++; end
    chk("burst_grant", grant, 2'b01);
    n = 0; na = 0; nr = 0; pe = 1'b0;
    while (grant === 2'b01 && n < 400) begin
      n++;
      if (ack[0]) na++;
      if (lcd_e && !pe) begin
        if (nr < 3) begin rt[nr] = n; rdv[nr] = lcd_data; end
        nr++;
      end
      pe = lcd_e;
      @(negedge clk);
    end
    chk("burst_acks", na, 3);
    chk("burst_pulses", nr, 3);
    chk("burst_grant_cycles", n, 30);
    chk("burst_spacing1", rt[1] - rt[0], S + E + SH);
    chk("burst_spacing2", rt[2] - rt[1], S + E + SH);
    for (int i = 0; i < 3; i++) chk($sformatf("burst_byte%0d", i), rdv[i], exp_burst[i]);
    chk("burst_release", grant, 2'b00);
    wait_idle();

    // Client 1: home command is slow, same byte as data is fast.
    push(1, 1'b0, 8'h02, 1'b1);
    count_grant(2'b10, n);
    chk("home_cmd_cycles", n, S + E + L);
    wait_idle();
    push(1, 1'b1, 8'h02, 1'b1);
    count_grant(2'b10, n);
    chk("data02_cycles", n, S + E + SH);
    wait_idle();

    // Client 0 drops req after its first ack without last.
    push(0, 1'b1, 8'h55, 1'b0);
    count_grant(2'b01, n);
    chk("drop_cycles", n, S + E + SH);
    chk("drop_grant", grant, 2'b00);
    chk("drop_idle", busy, 0);
    wait_idle();

    // Random traffic checked cycle by cycle against the model.
    rnd_en = 1'b1;
    repeat (2500) @(negedge clk);
    rnd_en = 1'b0;
    wait_idle();

    // Reset while E is high.
    push(1, 1'b1, 8'h5A, 1'b1);
    first_rise(n);
    chk("pre_reset_e", lcd_e, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_drop_e", lcd_e, 0);
    chk("async_busy", busy, 1);
    chk("async_grant", grant, 2'b00);
    q0.delete();
    q1.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    first_rise(cyc);
    chk("restart_first_rise", cyc, 22);
    n = 0;
    while (!init_done && n < 200) begin @(negedge clk); n++; end
    chk("restart_init_done", init_done, 1);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
